// File: rtl/console_pkg.sv
// Shared types and constants for the text console write controller.
// Optional backspace handling is enabled by defining TEXT_CONSOLE_BS_EN.
package console_pkg;

   typedef enum logic [1:0] {
      S_CLEAR,
      S_IDLE,
      S_WRITE,
      S_CLRLINE
   } console_state_t;

   localparam int CHAR_ADDR_W = 11;

   localparam logic [6:0] CHAR_SPACE = 7'h20;
   localparam logic [6:0] CHAR_LF    = 7'h0A;
   localparam logic [6:0] CHAR_CR    = 7'h0D;
   localparam logic [6:0] CHAR_FF    = 7'h0C;
   localparam logic [6:0] CHAR_BS    = 7'h08;
   localparam logic [6:0] CHAR_DEL   = 7'h7F;

   // Character RAM address layout shared with the display read side.
   function automatic logic [CHAR_ADDR_W-1:0] packAddr(input logic [5:0] col,
                                                       input logic [4:0] row);
      return {col, row};
   endfunction

endpackage

// File: rtl/console_sweep.sv
// Sweep counter shared by the full-screen clear and the single-line clear.
// Load starts the count at 1 because the caller issues index 0 on the load cycle itself.
module console_sweep
   import console_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   i_load,
   input  logic                   i_full,
   input  logic                   i_step,
   output logic [CHAR_ADDR_W-1:0] o_count,
   output logic                   o_done
);

   logic [CHAR_ADDR_W-1:0] r_count;
   logic                   r_done;
   logic                   r_full;
   logic                   w_last;

   assign w_last  = r_full ? (r_count == 11'h7FF) : (r_count[5:0] == 6'h3F);
   assign o_count = r_count;
   assign o_done  = r_done;

   // Out of reset the counter is already armed for a full sweep from address 0.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
         r_done  <= 1'b0;
         r_full  <= 1'b1;
      end else if (i_load) begin
         r_count <= 11'd1;
         r_done  <= 1'b0;
         r_full  <= i_full;
      end else if (i_step && !r_done) begin
         if (w_last) begin
            r_done <= 1'b1;
         end else begin
            r_count <= r_count + 11'd1;
         end
      end
   end

endmodule

// File: rtl/text_console_ctrl.sv
// Terminal-style writer for the character RAM: stores, line clears, screen clears.
// Define TEXT_CONSOLE_BS_EN to make 0x08 erase the character left of the cursor.
module text_console_ctrl
   import console_pkg::*;
#(
   parameter int COLS = 64,
   parameter int ROWS = 30
)
(
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   char_valid,
   input  logic [6:0]             char_data,
   output logic                   char_ready,
   input  logic                   clear_req,
   output logic                   ram_we,
   output logic [CHAR_ADDR_W-1:0] ram_write_addr,
   output logic [6:0]             ram_write_data,
   output logic [5:0]             cursor_col,
   output logic [4:0]             cursor_row,
   output logic                   busy
);

   localparam logic [5:0] LAST_COL = 6'(COLS - 1);
   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

   console_state_t         r_state, w_stateNext;
   logic                   r_ramWe, w_weNext;
   logic [CHAR_ADDR_W-1:0] r_ramAddr, w_addrNext;
   logic [6:0]             r_ramData, w_dataNext;
   logic [5:0]             r_col, w_colNext;
   logic [4:0]             r_row, w_rowNext;
   logic                   r_wrap, w_wrapNext;
   logic                   r_busy;
   logic [4:0]             w_rowInc;
   logic                   w_load, w_full, w_step, w_done;
   logic [CHAR_ADDR_W-1:0] w_count;

   console_sweep u_sweep (
      .clock   (clock),
      .reset_n (reset_n),
      .i_load  (w_load),
      .i_full  (w_full),
      .i_step  (w_step),
      .o_count (w_count),
      .o_done  (w_done)
   );

   assign char_ready     = (r_state == S_IDLE) && !clear_req;
   assign w_rowInc       = (r_row == LAST_ROW) ? 5'd0 : r_row + 5'd1;
   assign ram_we         = r_ramWe;
   assign ram_write_addr = r_ramAddr;
   assign ram_write_data = r_ramData;
   assign cursor_col     = r_col;
   assign cursor_row     = r_row;
   assign busy           = r_busy;

   // Each branch decides the write issued on the next edge; sweeps issue index 0 on entry.
   always_comb begin
      w_stateNext = r_state;
      w_weNext    = 1'b0;
      w_addrNext  = r_ramAddr;
      w_dataNext  = r_ramData;
      w_colNext   = r_col;
      w_rowNext   = r_row;
      w_wrapNext  = r_wrap;
      w_load      = 1'b0;
      w_full      = 1'b1;
      w_step      = 1'b0;
      case (r_state)
         S_CLEAR: begin
            if (!w_done) begin
               w_weNext   = 1'b1;
               w_addrNext = w_count;
               w_dataNext = CHAR_SPACE;
               w_step     = 1'b1;
            end else begin
               w_stateNext = S_IDLE;
            end
         end
         S_IDLE: begin
            if (clear_req || (char_valid && char_data == CHAR_FF)) begin
               w_weNext    = 1'b1;
               w_addrNext  = '0;
               w_dataNext  = CHAR_SPACE;
               w_load      = 1'b1;
               w_colNext   = '0;
               w_rowNext   = '0;
               w_stateNext = S_CLEAR;
            end else if (char_valid) begin
               if (char_data >= CHAR_SPACE && char_data != CHAR_DEL) begin
                  w_weNext    = 1'b1;
                  w_addrNext  = packAddr(r_col, r_row);
                  w_dataNext  = char_data;
                  w_stateNext = S_WRITE;
                  if (r_col == LAST_COL) begin
                     w_colNext  = '0;
                     w_rowNext  = w_rowInc;
                     w_wrapNext = 1'b1;
                  end else begin
                     w_colNext  = r_col + 6'd1;
                     w_wrapNext = 1'b0;
                  end
               end else if (char_data == CHAR_LF) begin
                  w_weNext    = 1'b1;
                  w_addrNext  = packAddr(6'd0, w_rowInc);
                  w_dataNext  = CHAR_SPACE;
                  w_load      = 1'b1;
                  w_full      = 1'b0;
                  w_colNext   = '0;
                  w_rowNext   = w_rowInc;
                  w_stateNext = S_CLRLINE;
               end else if (char_data == CHAR_CR) begin
                  w_colNext = '0;
               end
`ifdef TEXT_CONSOLE_BS_EN
               else if (char_data == CHAR_BS && r_col != 6'd0) begin
                  w_weNext    = 1'b1;
                  w_addrNext  = packAddr(r_col - 6'd1, r_row);
                  w_dataNext  = CHAR_SPACE;
                  w_colNext   = r_col - 6'd1;
                  w_wrapNext  = 1'b0;
                  w_stateNext = S_WRITE;
               end
`endif
            end
         end
         S_WRITE: begin
            if (r_wrap) begin
               w_weNext    = 1'b1;
               w_addrNext  = packAddr(6'd0, r_row);
               w_dataNext  = CHAR_SPACE;
               w_load      = 1'b1;
               w_full      = 1'b0;
               w_wrapNext  = 1'b0;
               w_stateNext = S_CLRLINE;
            end else begin
               w_stateNext = S_IDLE;
            end
         end
         S_CLRLINE: begin
            if (!w_done) begin
               w_weNext   = 1'b1;
               w_addrNext = packAddr(w_count[5:0], r_row);
               w_dataNext = CHAR_SPACE;
               w_step     = 1'b1;
            end else begin
               w_stateNext = S_IDLE;
            end
         end
         default: w_stateNext = S_CLEAR;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_CLEAR;
         r_ramWe   <= 1'b0;
         r_ramAddr <= '0;
         r_ramData <= CHAR_SPACE;
         r_col     <= '0;
         r_row     <= '0;
         r_wrap    <= 1'b0;
         r_busy    <= 1'b1;
      end else begin
         r_state   <= w_stateNext;
         r_ramWe   <= w_weNext;
         r_ramAddr <= w_addrNext;
         r_ramData <= w_dataNext;
         r_col     <= w_colNext;
         r_row     <= w_rowNext;
         r_wrap    <= w_wrapNext;
         r_busy    <= (w_stateNext != S_IDLE);
      end
   end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed, table-driven bench for text_console_ctrl; expectations are hand-computed.
module tb_text_console_ctrl;

   logic        clock;
   logic        reset_n;
   logic        char_valid;
   logic [6:0]  char_data;
   logic        char_ready;
   logic        clear_req;
   logic        ram_we;
   logic [10:0] ram_write_addr;
   logic [6:0]  ram_write_data;
   logic [5:0]  cursor_col;
   logic [4:0]  cursor_row;
   logic        busy;

   int nCompared = 0;
   int nMismatch = 0;

   logic [10:0] logAddr[$];
   logic [6:0]  logData[$];

   typedef struct {
      logic [6:0]  ch;
      int          nWrites;
      logic [10:0] addr0;
      logic [6:0]  data0;
      logic [5:0]  col;
      logic [4:0]  row;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   text_console_ctrl #(.COLS(64), .ROWS(30)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .char_valid     (char_valid),
      .char_data      (char_data),
      .char_ready     (char_ready),
      .clear_req      (clear_req),
      .ram_we         (ram_we),
      .ram_write_addr (ram_write_addr),
      .ram_write_data (ram_write_data),
      .cursor_col     (cursor_col),
      .cursor_row     (cursor_row),
      .busy           (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Every RAM write seen mid-cycle is logged for later inspection.
   always @(negedge clock) begin
      if (ram_we === 1'b1) begin
         logAddr.push_back(ram_write_addr);
         logData.push_back(ram_write_data);
      end
   end

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatch++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called with reset_n low; checks reset values, releases, then checks the 2048-write sweep.
   task automatic checkResetSweep(input string name);
      int bad;
      bad = 0;
      @(negedge clock);
      checkOutput({name, "_rst_we"}, 32'(ram_we), 32'd0);
      checkOutput({name, "_rst_addr"}, 32'(ram_write_addr), 32'd0);
      checkOutput({name, "_rst_data"}, 32'(ram_write_data), 32'h20);
      checkOutput({name, "_rst_ready"}, 32'(char_ready), 32'd0);
      checkOutput({name, "_rst_busy"}, 32'(busy), 32'd1);
      checkOutput({name, "_rst_cursor"}, {26'd0, cursor_col}, 32'd0);
      checkOutput({name, "_rst_row"}, {27'd0, cursor_row}, 32'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 2048; i++) begin
         @(negedge clock);
         if (!(ram_we === 1'b1 && ram_write_addr === 11'(i) && ram_write_data === 7'h20
               && busy === 1'b1 && char_ready === 1'b0))
            bad++;
      end
      checkOutput({name, "_sweep_bad_cycles"}, 32'(bad), 32'd0);
      @(negedge clock);
      checkOutput({name, "_ready_2049"}, 32'(char_ready), 32'd1);
      checkOutput({name, "_we_after"}, 32'(ram_we), 32'd0);
      checkOutput({name, "_busy_after"}, 32'(busy), 32'd0);
      checkOutput({name, "_home"}, {21'd0, cursor_col, cursor_row}, 32'd0);
   endtask

   // Presents one character from a negedge in an IDLE cycle; returns one cycle after acceptance.
   task automatic sendRaw(input logic [6:0] c);
      char_data  = c;
      char_valid = 1'b1;
      #1;
      checkOutput($sformatf("ready_before_0x%0h", c), 32'(char_ready), 32'd1);
      @(posedge clock);
      #1;
      char_valid = 1'b0;
   endtask

   // Latency counts cycles from acceptance to char_ready; optionally pulses clear_req at cycle pulseAt.
   task automatic waitReady(input int pulseAt, output int lat);
      lat = 1;
      @(negedge clock);
      while (!char_ready && lat < 3000) begin
         clear_req = (lat == pulseAt);
         @(negedge clock);
         lat++;
      end
      clear_req = 1'b0;
      if (char_ready !== 1'b1) checkOutput("ready_timeout", 32'(char_ready), 32'd1);
   endtask

   task automatic applyStimulus(input logic [6:0] c, output int lat);
      logAddr.delete();
      logData.delete();
      sendRaw(c);
      waitReady(-1, lat);
   endtask

   // Checks logged writes [start, start+n) against a full-screen or single-row space sweep.
   task automatic checkSweepLog(input string name, input int start, input int n,
                                input bit full, input logic [4:0] row);
      int bad;
      logic [10:0] exp;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         exp = full ? 11'(i) : {i[5:0], row};
         if (start + i >= logAddr.size()) bad++;
         else if (logAddr[start+i] !== exp || logData[start+i] !== 7'h20) bad++;
      end
      checkOutput({name, "_sweep_bad"}, 32'(bad), 32'd0);
   endtask

   int lat;

   initial begin
      reset_n    = 1'b0;
      clear_req  = 1'b0;
      char_valid = 1'b0;
      char_data  = 7'h00;

      vecs[0]  = '{7'h41, 1, 11'h000, 7'h41, 6'd1, 5'd0, 2};
      vecs[1]  = '{7'h62, 1, 11'h020, 7'h62, 6'd2, 5'd0, 2};
      vecs[2]  = '{7'h0D, 0, 11'h000, 7'h00, 6'd0, 5'd0, 1};
      vecs[3]  = '{7'h01, 0, 11'h000, 7'h00, 6'd0, 5'd0, 1};
      vecs[4]  = '{7'h0A, 64, 11'h001, 7'h20, 6'd0, 5'd1, 65};
      vecs[5]  = '{7'h5A, 1, 11'h001, 7'h5A, 6'd1, 5'd1, 2};
      vecs[6]  = '{7'h7F, 0, 11'h000, 7'h00, 6'd1, 5'd1, 1};
      vecs[7]  = '{7'h7E, 1, 11'h021, 7'h7E, 6'd2, 5'd1, 2};
      vecs[8]  = '{7'h1B, 0, 11'h000, 7'h00, 6'd2, 5'd1, 1};
`ifdef TEXT_CONSOLE_BS_EN
      vecs[9]  = '{7'h08, 1, 11'h021, 7'h20, 6'd1, 5'd1, 2};
`else
      vecs[9]  = '{7'h08, 0, 11'h000, 7'h00, 6'd2, 5'd1, 1};
`endif
      vecs[10] = '{7'h0D, 0, 11'h000, 7'h00, 6'd0, 5'd1, 1};
      vecs[11] = '{7'h08, 0, 11'h000, 7'h00, 6'd0, 5'd1, 1};

      checkResetSweep("por");

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].ch, lat);
         checkOutput($sformatf("v%0d_nwrites", i), 32'(logAddr.size()), 32'(vecs[i].nWrites));
         if (vecs[i].nWrites > 0 && logAddr.size() > 0) begin
            checkOutput($sformatf("v%0d_addr", i), 32'(logAddr[0]), 32'(vecs[i].addr0));
            checkOutput($sformatf("v%0d_data", i), 32'(logData[0]), 32'(vecs[i].data0));
         end
         if (vecs[i].nWrites == 64) checkSweepLog($sformatf("v%0d", i), 0, 64, 1'b0, vecs[i].row);
         checkOutput($sformatf("v%0d_col", i), 32'(cursor_col), 32'(vecs[i].col));
         checkOutput($sformatf("v%0d_row", i), 32'(cursor_row), 32'(vecs[i].row));
         checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      end

      // Line wrap at column 63 of row 5.
      applyStimulus(7'h0D, lat);
      repeat (4) applyStimulus(7'h0A, lat);
      repeat (63) applyStimulus(7'h61, lat);
      checkOutput("wrap_pre_col", 32'(cursor_col), 32'd63);
      applyStimulus(7'h42, lat);
      checkOutput("wrap_nwrites", 32'(logAddr.size()), 32'd65);
      checkOutput("wrap_char_addr", 32'(logAddr[0]), 32'h7E5);
      checkOutput("wrap_char_data", 32'(logData[0]), 32'h42);
      checkSweepLog("wrap", 1, 64, 1'b0, 5'd6);
      checkOutput("wrap_latency", 32'(lat), 32'd66);
      checkOutput("wrap_cursor", {21'd0, cursor_col, cursor_row}, {21'd0, 6'd0, 5'd6});

      // LF on the last visible row wraps to row 0.
      repeat (23) applyStimulus(7'h0A, lat);
      repeat (10) applyStimulus(7'h61, lat);
      checkOutput("rowwrap_pre", {21'd0, cursor_col, cursor_row}, {21'd0, 6'd10, 5'd29});
      applyStimulus(7'h0A, lat);
      checkOutput("rowwrap_nwrites", 32'(logAddr.size()), 32'd64);
      checkSweepLog("rowwrap", 0, 64, 1'b0, 5'd0);
      checkOutput("rowwrap_cursor", {21'd0, cursor_col, cursor_row}, 32'd0);
      checkOutput("rowwrap_latency", 32'(lat), 32'd65);
      applyStimulus(7'h0D, lat);
      checkOutput("cr_nwrites", 32'(logAddr.size()), 32'd0);
      checkOutput("cr_latency", 32'(lat), 32'd1);
      applyStimulus(7'h01, lat);
      checkOutput("ctl_nwrites", 32'(logAddr.size()), 32'd0);
      checkOutput("ctl_latency", 32'(lat), 32'd1);

      // clear_req beats a same-cycle character.
      applyStimulus(7'h78, lat);
      logAddr.delete();
      logData.delete();
      clear_req  = 1'b1;
      char_valid = 1'b1;
      char_data  = 7'h51;
      #1;
      checkOutput("clr_ready_blocked", 32'(char_ready), 32'd0);
      @(posedge clock);
      #1;
      clear_req  = 1'b0;
      char_valid = 1'b0;
      waitReady(-1, lat);
      checkOutput("clr_nwrites", 32'(logAddr.size()), 32'd2048);
      checkSweepLog("clr", 0, 2048, 1'b1, 5'd0);
      checkOutput("clr_latency", 32'(lat), 32'd2049);
      checkOutput("clr_cursor", {21'd0, cursor_col, cursor_row}, 32'd0);

      // Form feed behaves as a clear request.
      applyStimulus(7'h79, lat);
      applyStimulus(7'h0C, lat);
      checkOutput("ff_nwrites", 32'(logAddr.size()), 32'd2048);
      checkSweepLog("ff", 0, 2048, 1'b1, 5'd0);
      checkOutput("ff_latency", 32'(lat), 32'd2049);
      checkOutput("ff_cursor", {21'd0, cursor_col, cursor_row}, 32'd0);

      // clear_req during CLRLINE is ignored.
      logAddr.delete();
      logData.delete();
      sendRaw(7'h0A);
      waitReady(10, lat);
      checkOutput("ign_clr_nwrites", 32'(logAddr.size()), 32'd64);
      checkOutput("ign_clr_latency", 32'(lat), 32'd65);
      checkOutput("ign_clr_cursor", {21'd0, cursor_col, cursor_row}, {21'd0, 6'd0, 5'd1});

      // Reset mid-CLRLINE restarts the full clear from address 0.
      sendRaw(7'h0A);
      repeat (10) @(negedge clock);
      reset_n = 1'b0;
      checkResetSweep("midrst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
